// File: rtl/axi_cache_port_mux.sv
// Multiplexes NumPorts cache-side AXI masters onto one memory-side AXI port.
// Define AXI_CACHE_PORT_MUX_RR_EN for round-robin AR/AW arbitration; the default is fixed priority.
package axi_cache_port_mux_pkg;
   localparam int unsigned IdW = 4;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [31:0]    addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
   } ax_chan_t;

   typedef ax_chan_t ar_chan_t;
   typedef ax_chan_t aw_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [31:0]    data;
      logic [1:0]     resp;
      logic           last;
   } r_chan_t;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [1:0]     resp;
   } b_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } rsp_t;
endpackage

module axi_cache_port_mux #(
   parameter int unsigned NumPorts       = 3,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned WFifoDepth     = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter type axi_req_t     = axi_cache_port_mux_pkg::req_t,
   parameter type axi_rsp_t     = axi_cache_port_mux_pkg::rsp_t,
   parameter type axi_ar_chan_t = axi_cache_port_mux_pkg::ar_chan_t,
   parameter type axi_aw_chan_t = axi_cache_port_mux_pkg::aw_chan_t,
   parameter type axi_w_chan_t  = axi_cache_port_mux_pkg::w_chan_t
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  axi_req_t [NumPorts-1:0]  port_req_i,
   output axi_rsp_t [NumPorts-1:0]  port_rsp_o,
   output axi_req_t                 axi_req_o,
   input  axi_rsp_t                 axi_rsp_i,
   output logic                     busy_o,
   output logic                     id_err_o
);
   localparam int unsigned PW = $clog2(NumPorts);
   localparam int unsigned LW = IdWidth - PW;
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned FW = $clog2(WFifoDepth);
   localparam logic [CW-1:0] CntMax = CW'(MaxOutstanding);

   logic [CW-1:0] rd_cnt_q [NumPorts];
   logic [CW-1:0] rd_cnt_d [NumPorts];
   logic [CW-1:0] wr_cnt_q [NumPorts];
   logic [CW-1:0] wr_cnt_d [NumPorts];
   logic          ar_lock_q, ar_lock_d, aw_lock_q, aw_lock_d;
   logic [PW-1:0] ar_gnt_q, ar_gnt_d, aw_gnt_q, aw_gnt_d;
   logic [PW-1:0] fifo_mem_q [WFifoDepth];
   logic [PW-1:0] fifo_mem_d [WFifoDepth];
   logic [FW:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic          w_done_q, w_done_d;
   logic          id_err_q, id_err_d;
   logic          busy_q, busy_d;

   logic [NumPorts-1:0] ar_req, aw_req;
   logic [PW-1:0]       ar_sel, aw_sel, w_sel, r_port, b_port, fifo_head;
   logic                ar_vld, ar_hs, aw_vld, aw_hs;
   logic                w_en, w_vld, w_last_hs;
   logic                r_ok, b_ok, r_rdy, b_rdy, r_hs, b_hs;
   logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
   int                  ar_start, aw_start;
   axi_ar_chan_t        ar_out;
   axi_aw_chan_t        aw_out;
   axi_w_chan_t         w_out;

   // First requesting index at or after start, wrapping modulo NumPorts.
   function automatic logic [PW-1:0] pick(input logic [NumPorts-1:0] req, input int start);
      logic [PW-1:0] res;
      logic [PW-1:0] idx_l;
      logic          found;
      int            idx;
      res   = '0;
      found = 1'b0;
      for (int k = 0; k < NumPorts; k++) begin
         idx = start + k;
         if (idx >= NumPorts) idx = idx - NumPorts;
         idx_l = PW'(idx);
         if (!found && req[idx_l]) begin
            res   = idx_l;
            found = 1'b1;
         end
      end
      return res;
   endfunction

`ifdef AXI_CACHE_PORT_MUX_RR_EN
   logic [PW-1:0] ar_rr_q, ar_rr_d, aw_rr_q, aw_rr_d;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
      return (32'(idx) == NumPorts - 1) ? '0 : idx + 1'b1;
   endfunction

   assign ar_start = int'(ar_rr_q);
   assign aw_start = int'(aw_rr_q);
   assign ar_rr_d  = ar_hs ? next_idx(ar_sel) : ar_rr_q;
   assign aw_rr_d  = aw_hs ? next_idx(aw_sel) : aw_rr_q;
`else
   assign ar_start = 0;
   assign aw_start = 0;
`endif

   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         ar_req[i] = port_req_i[i].ar_valid && (rd_cnt_q[i] != CntMax);
         aw_req[i] = port_req_i[i].aw_valid && (wr_cnt_q[i] != CntMax);
      end
   end

   assign ar_sel = ar_lock_q ? ar_gnt_q : pick(ar_req, ar_start);
   assign aw_sel = aw_lock_q ? aw_gnt_q : pick(aw_req, aw_start);
   assign ar_vld = rst_ni && (ar_lock_q ? port_req_i[ar_sel].ar_valid : |ar_req);
   assign aw_vld = rst_ni && !fifo_full && (aw_lock_q ? port_req_i[aw_sel].aw_valid : |aw_req);
   assign ar_hs  = ar_vld && axi_rsp_i.ar_ready;
   assign aw_hs  = aw_vld && axi_rsp_i.aw_ready;

   assign fifo_empty = (fifo_wr_q == fifo_rd_q);
   assign fifo_full  = (fifo_wr_q[FW] != fifo_rd_q[FW]) && (fifo_wr_q[FW-1:0] == fifo_rd_q[FW-1:0]);
   assign fifo_head  = fifo_mem_q[fifo_rd_q[FW-1:0]];

   // w_done_q marks a fall-through burst that finished before its AW was accepted.
   assign w_sel     = fifo_empty ? aw_sel : fifo_head;
   assign w_en      = rst_ni && (fifo_empty ? (aw_vld && !w_done_q) : 1'b1);
   assign w_vld     = w_en && port_req_i[w_sel].w_valid;
   assign w_last_hs = w_vld && axi_rsp_i.w_ready && port_req_i[w_sel].w.last;
   assign fifo_push = aw_hs && !w_done_q && !(fifo_empty && w_last_hs);
   assign fifo_pop  = w_last_hs && !fifo_empty;

   assign r_port = axi_rsp_i.r.id[IdWidth-1 -: PW];
   assign b_port = axi_rsp_i.b.id[IdWidth-1 -: PW];
   assign r_ok   = 32'(r_port) < NumPorts;
   assign b_ok   = 32'(b_port) < NumPorts;
   assign r_rdy  = rst_ni && (r_ok ? port_req_i[r_port].r_ready : 1'b1);
   assign b_rdy  = rst_ni && (b_ok ? port_req_i[b_port].b_ready : 1'b1);
   assign r_hs   = axi_rsp_i.r_valid && r_rdy;
   assign b_hs   = axi_rsp_i.b_valid && b_rdy;

   always_comb begin
      ar_out    = port_req_i[ar_sel].ar;
      ar_out.id = {ar_sel, port_req_i[ar_sel].ar.id[LW-1:0]};
      aw_out    = port_req_i[aw_sel].aw;
      aw_out.id = {aw_sel, port_req_i[aw_sel].aw.id[LW-1:0]};
      w_out     = port_req_i[w_sel].w;
      axi_req_o          = '0;
      axi_req_o.ar       = ar_out;
      axi_req_o.ar_valid = ar_vld;
      axi_req_o.aw       = aw_out;
      axi_req_o.aw_valid = aw_vld;
      axi_req_o.w        = w_out;
      axi_req_o.w_valid  = w_vld;
      axi_req_o.r_ready  = r_rdy;
      axi_req_o.b_ready  = b_rdy;
   end

   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         port_rsp_o[i]          = '0;
         port_rsp_o[i].ar_ready = ar_vld && axi_rsp_i.ar_ready && (ar_sel == PW'(i));
         port_rsp_o[i].aw_ready = aw_vld && axi_rsp_i.aw_ready && (aw_sel == PW'(i));
         port_rsp_o[i].w_ready  = w_en && axi_rsp_i.w_ready && (w_sel == PW'(i));
         port_rsp_o[i].r        = axi_rsp_i.r;
         port_rsp_o[i].r.id     = {{PW{1'b0}}, axi_rsp_i.r.id[LW-1:0]};
         port_rsp_o[i].r_valid  = rst_ni && axi_rsp_i.r_valid && r_ok && (r_port == PW'(i));
         port_rsp_o[i].b        = axi_rsp_i.b;
         port_rsp_o[i].b.id     = {{PW{1'b0}}, axi_rsp_i.b.id[LW-1:0]};
         port_rsp_o[i].b_valid  = rst_ni && axi_rsp_i.b_valid && b_ok && (b_port == PW'(i));
      end
   end

   always_comb begin
      busy_d = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
         rd_cnt_d[i] = rd_cnt_q[i];
         wr_cnt_d[i] = wr_cnt_q[i];
         case ({ar_hs && (ar_sel == PW'(i)),
                r_hs && r_ok && axi_rsp_i.r.last && (r_port == PW'(i))})
            2'b10:   rd_cnt_d[i] = rd_cnt_q[i] + 1'b1;
            2'b01:   rd_cnt_d[i] = rd_cnt_q[i] - 1'b1;
            default: rd_cnt_d[i] = rd_cnt_q[i];
         endcase
         case ({aw_hs && (aw_sel == PW'(i)), b_hs && b_ok && (b_port == PW'(i))})
            2'b10:   wr_cnt_d[i] = wr_cnt_q[i] + 1'b1;
            2'b01:   wr_cnt_d[i] = wr_cnt_q[i] - 1'b1;
            default: wr_cnt_d[i] = wr_cnt_q[i];
         endcase
         if ((rd_cnt_q[i] != '0) || (wr_cnt_q[i] != '0)) busy_d = 1'b1;
      end
   end

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      if (fifo_push) fifo_mem_d[fifo_wr_q[FW-1:0]] = aw_sel;
      fifo_wr_d = fifo_wr_q + (FW+1)'(fifo_push);
      fifo_rd_d = fifo_rd_q + (FW+1)'(fifo_pop);
      if (aw_hs)                         w_done_d = 1'b0;
      else if (fifo_empty && w_last_hs)  w_done_d = 1'b1;
      else                               w_done_d = w_done_q;
      ar_lock_d = ar_vld && !axi_rsp_i.ar_ready;
      aw_lock_d = aw_vld && !axi_rsp_i.aw_ready;
      ar_gnt_d  = ar_sel;
      aw_gnt_d  = aw_sel;
      id_err_d  = id_err_q || (axi_rsp_i.r_valid && !r_ok) || (axi_rsp_i.b_valid && !b_ok);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumPorts; i++) begin
            rd_cnt_q[i] <= '0;
            wr_cnt_q[i] <= '0;
         end
         for (int j = 0; j < WFifoDepth; j++) fifo_mem_q[j] <= '0;
         fifo_wr_q <= '0;
         fifo_rd_q <= '0;
         w_done_q  <= 1'b0;
         ar_lock_q <= 1'b0;
         aw_lock_q <= 1'b0;
         ar_gnt_q  <= '0;
         aw_gnt_q  <= '0;
         id_err_q  <= 1'b0;
         busy_q    <= 1'b0;
`ifdef AXI_CACHE_PORT_MUX_RR_EN
         ar_rr_q   <= '0;
         aw_rr_q   <= '0;
`endif
      end else begin
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         fifo_mem_q <= fifo_mem_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_rd_q  <= fifo_rd_d;
         w_done_q   <= w_done_d;
         ar_lock_q  <= ar_lock_d;
         aw_lock_q  <= aw_lock_d;
         ar_gnt_q   <= ar_gnt_d;
         aw_gnt_q   <= aw_gnt_d;
         id_err_q   <= id_err_d;
         busy_q     <= busy_d;
`ifdef AXI_CACHE_PORT_MUX_RR_EN
         ar_rr_q    <= ar_rr_d;
         aw_rr_q    <= aw_rr_d;
`endif
      end
   end

   assign busy_o   = busy_q;
   assign id_err_o = id_err_q;
endmodule

// File: tb/tb_axi_cache_port_mux.sv
// Directed bench for axi_cache_port_mux: response demux table plus multi-cycle sequences.
module tb_axi_cache_port_mux;
   import axi_cache_port_mux_pkg::*;

`ifdef AXI_CACHE_PORT_MUX_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   req_t [2:0]      port_req;
   rsp_t [2:0]      port_rsp;
   req_t            axi_req;
   rsp_t            axi_rsp;
   logic            busy;
   logic            id_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       is_b;
      logic [3:0] id;
      logic [2:0] rdy;
      logic [2:0] exp_vld;
      logic       exp_rdy;
      logic [3:0] exp_id;
   } vec_t;

   vec_t vecs [6];

   axi_cache_port_mux dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .port_req_i (port_req),
      .port_rsp_o (port_rsp),
      .axi_req_o  (axi_req),
      .axi_rsp_i  (axi_rsp),
      .busy_o     (busy),
      .id_err_o   (id_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      port_req = '0;
      axi_rsp  = '0;
      rst_n    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] got;
      logic [3:0] gid;
      int         p;

      vecs[0] = '{1'b0, 4'b0111, 3'b010, 3'b010, 1'b1, 4'd3};
      vecs[1] = '{1'b0, 4'b0001, 3'b000, 3'b001, 1'b0, 4'd1};
      vecs[2] = '{1'b0, 4'b1010, 3'b100, 3'b100, 1'b1, 4'd2};
      vecs[3] = '{1'b0, 4'b0100, 3'b101, 3'b010, 1'b0, 4'd0};
      vecs[4] = '{1'b1, 4'b1001, 3'b100, 3'b100, 1'b1, 4'd1};
      vecs[5] = '{1'b1, 4'b0010, 3'b110, 3'b001, 1'b0, 4'd2};

      // Reset: outputs quiet even with requests present.
      port_req = '0;
      axi_rsp  = '0;
      rst_n    = 1'b0;
      port_req[0].ar_valid = 1'b1;
      axi_rsp.ar_ready     = 1'b1;
      tick();
      chk("rst_ar_valid", axi_req.ar_valid, 0);
      chk("rst_ar_ready", port_rsp[0].ar_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_id_err", id_err, 0);
      do_reset();

      // Response demux table.
      for (int i = 0; i < 6; i++) begin
         axi_rsp = '0;
         if (vecs[i].is_b) begin
            axi_rsp.b_valid = 1'b1;
            axi_rsp.b.id    = vecs[i].id;
         end else begin
            axi_rsp.r_valid = 1'b1;
            axi_rsp.r.id    = vecs[i].id;
            axi_rsp.r.data  = 32'hA500_0000 + i;
         end
         for (int k = 0; k < 3; k++) begin
            port_req[k].r_ready = vecs[i].rdy[k];
            port_req[k].b_ready = vecs[i].rdy[k];
         end
         #1;
         p = 0;
         for (int k = 0; k < 3; k++) begin
            got[k] = vecs[i].is_b ? port_rsp[k].b_valid : port_rsp[k].r_valid;
            if (vecs[i].exp_vld[k]) p = k;
         end
         gid = vecs[i].is_b ? port_rsp[p].b.id : port_rsp[p].r.id;
         chk("demux_valid", got, vecs[i].exp_vld);
         chk("demux_ready", vecs[i].is_b ? axi_req.b_ready : axi_req.r_ready, vecs[i].exp_rdy);
         chk("demux_id", gid, vecs[i].exp_id);
         $display("vec %0d %s id=%b port_valid=%b ready=%b stripped_id=%0d",
                  i, vecs[i].is_b ? "B" : "R", vecs[i].id, got,
                  vecs[i].is_b ? axi_req.b_ready : axi_req.r_ready, gid);
         tick();
      end
      do_reset();

      // Port 1 read round trip with ID remap and busy latency.
      port_req[1].ar_valid = 1'b1;
      port_req[1].ar.id    = 4'd3;
      port_req[1].ar.addr  = 32'h1000;
      axi_rsp.ar_ready     = 1'b1;
      #1;
      chk("ar_id_remap", axi_req.ar.id, 4'b0111);
      chk("ar_ready_p1", port_rsp[1].ar_ready, 1);
      $display("txn AR port1 id=3 -> mem id=%b", axi_req.ar.id);
      tick();
      port_req[1].ar_valid = 1'b0;
      chk("busy_lag", busy, 0);
      tick();
      chk("busy_set", busy, 1);
      axi_rsp.r_valid   = 1'b1;
      axi_rsp.r.id      = 4'b0111;
      axi_rsp.r.last    = 1'b1;
      axi_rsp.r.data    = 32'h1234_5678;
      port_req[1].r_ready = 1'b1;
      #1;
      chk("r_valid_p1", port_rsp[1].r_valid, 1);
      chk("r_id_p1", port_rsp[1].r.id, 4'd3);
      chk("r_data_p1", port_rsp[1].r.data, 32'h1234_5678);
      $display("txn R mem id=0111 -> port1 id=%0d", port_rsp[1].r.id);
      tick();
      axi_rsp.r_valid = 1'b0;
      chk("busy_hold", busy, 1);
      tick();
      chk("busy_clear", busy, 0);

      // Two contending AR ports.
      do_reset();
      port_req[0].ar_valid = 1'b1;
      port_req[0].ar.id    = 4'd1;
      port_req[2].ar_valid = 1'b1;
      port_req[2].ar.id    = 4'd2;
      axi_rsp.ar_ready     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("arb_grant", axi_req.ar.id[3:2], (RrEn && (k % 2 == 1)) ? 2 : 0);
         $display("txn AR grant %0d -> port %0d", k, axi_req.ar.id[3:2]);
         tick();
      end
      // Grant and payload held while stalled.
      port_req[0].ar_valid = 1'b0;
      axi_rsp.ar_ready     = 1'b0;
      #1;
      chk("hold_first", axi_req.ar.id, 4'b1010);
      tick();
      port_req[0].ar_valid = 1'b1;
      #1;
      chk("hold_grant", axi_req.ar.id, 4'b1010);
      axi_rsp.ar_ready = 1'b1;
      tick();
      port_req[2].ar_valid = 1'b0;
      #1;
      chk("after_hold", axi_req.ar.id, 4'b0001);
      $display("txn AR hold released, grant port %0d", axi_req.ar.id[3:2]);

      // W-order FIFO fills at WFifoDepth.
      do_reset();
      port_req[0].aw_valid = 1'b1;
      port_req[0].aw.id    = 4'd1;
      axi_rsp.aw_ready     = 1'b1;
      axi_rsp.w_ready      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("aw_accept", axi_req.aw_valid & port_rsp[0].aw_ready, 1);
         $display("txn AW %0d accepted", k);
         tick();
      end
      chk("aw_stall_full", axi_req.aw_valid, 0);
      chk("aw_ready_full", port_rsp[0].aw_ready, 0);
      port_req[0].w_valid = 1'b1;
      port_req[0].w.last  = 1'b1;
      port_req[0].w.data  = 32'hCAFE_0001;
      #1;
      chk("w_head_valid", axi_req.w_valid, 1);
      chk("w_head_ready", port_rsp[0].w_ready, 1);
      chk("aw_still_full", axi_req.aw_valid, 0);
      tick();
      port_req[0].w_valid = 1'b0;
      chk("aw_after_pop", axi_req.aw_valid, 1);
      $display("txn W last popped, AW resumes valid=%0d", axi_req.aw_valid);

      // Fall-through AW+W in one cycle, FIFO stays empty.
      do_reset();
      port_req[2].aw_valid = 1'b1;
      port_req[2].aw.id    = 4'd0;
      port_req[2].w_valid  = 1'b1;
      port_req[2].w.last   = 1'b1;
      port_req[2].w.data   = 32'hBEEF_0002;
      axi_rsp.aw_ready     = 1'b1;
      axi_rsp.w_ready      = 1'b1;
      #1;
      chk("ft_aw_ready", port_rsp[2].aw_ready, 1);
      chk("ft_w_ready", port_rsp[2].w_ready, 1);
      chk("ft_w_data", axi_req.w_valid ? axi_req.w.data : 32'h0, 32'hBEEF_0002);
      $display("txn AW+W port2 same cycle");
      tick();
      port_req[2].aw_valid = 1'b0;
      #1;
      chk("empty_no_w", axi_req.w_valid, 0);
      chk("empty_no_wready", {port_rsp[2].w_ready, port_rsp[1].w_ready, port_rsp[0].w_ready}, 0);
      port_req[2].w_valid  = 1'b0;
      port_req[1].aw_valid = 1'b1;
      port_req[1].w_valid  = 1'b1;
      port_req[1].w.last   = 1'b1;
      port_req[1].w.data   = 32'hBEEF_0001;
      #1;
      chk("ft_p1_w_data", axi_req.w.data, 32'hBEEF_0001);
      chk("ft_p1_w_ready", port_rsp[1].w_ready, 1);
      $display("txn AW+W port1 after empty FIFO");
      tick();
      port_req[1].aw_valid = 1'b0;
      port_req[1].w_valid  = 1'b0;
      axi_rsp.b_valid      = 1'b1;
      axi_rsp.b.id         = 4'b1000;
      port_req[2].b_ready  = 1'b1;
      #1;
      chk("b_valid_p2", port_rsp[2].b_valid, 1);
      chk("b_id_p2", port_rsp[2].b.id, 4'd0);
      tick();
      axi_rsp.b_valid = 1'b0;

      // Outstanding read limit with simultaneous inc/dec.
      do_reset();
      port_req[0].ar_valid = 1'b1;
      axi_rsp.ar_ready     = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      chk("limit_masked", axi_req.ar_valid, 0);
      chk("limit_ready", port_rsp[0].ar_ready, 0);
      port_req[1].ar_valid = 1'b1;
      port_req[1].ar.id    = 4'd2;
      #1;
      chk("limit_other_port", axi_req.ar.id, 4'b0110);
      port_req[1].ar_valid = 1'b0;
      axi_rsp.r_valid      = 1'b1;
      axi_rsp.r.id         = 4'b0000;
      axi_rsp.r.last       = 1'b1;
      port_req[0].r_ready  = 1'b1;
      #1;
      chk("limit_before_r", axi_req.ar_valid, 0);
      tick();
      chk("limit_after_r", axi_req.ar_valid, 1);
      tick();
      axi_rsp.r_valid = 1'b0;
      chk("limit_inc_dec", axi_req.ar_valid, 1);
      tick();
      chk("limit_again", axi_req.ar_valid, 0);
      $display("txn AR limit reached again, valid=%0d", axi_req.ar_valid);

      // Bad-port response.
      do_reset();
      axi_rsp.b_valid = 1'b1;
      axi_rsp.b.id    = 4'b1100;
      #1;
      chk("bad_b_ready", axi_req.b_ready, 1);
      chk("bad_b_valid", {port_rsp[2].b_valid, port_rsp[1].b_valid, port_rsp[0].b_valid}, 0);
      chk("bad_err_pre", id_err, 0);
      tick();
      axi_rsp.b_valid = 1'b0;
      chk("bad_err_set", id_err, 1);
      tick();
      tick();
      chk("bad_err_sticky", id_err, 1);
      $display("txn B id=1100 dropped, id_err=%0d", id_err);
      do_reset();
      chk("bad_err_reset", id_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
